// File: rtl/d_cache_wb_unit_pkg.sv
// Shared definitions for the D-cache dirty-line writeback engine:
// constants, AXI response codes and the writeback FSM encoding.
package d_cache_wb_unit_pkg;

  localparam logic [63:0] ZEROWORD           = 64'h0;
  localparam logic [1:0]  RESP_OKAY          = 2'b00;
  localparam int          WORDS_PER_LINE_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/d_cache_wb_unit_if.sv
// Request, data-RAM and AW/W/B bus signals of the writeback unit.
// Every valid/ready pair transfers on a cycle where both are high; the sender
// keeps valid and its payload stable until that cycle and never waits for ready.
interface d_cache_wb_unit_if #(
  parameter int LINE_IDX_W = 4,
  parameter int ADDR_W     = 64
);
  logic                  wb_req_valid;
  logic                  wb_req_ready;
  logic [LINE_IDX_W-1:0] wb_line_idx;
  logic [ADDR_W-1:0]     wb_addr;
  logic                  wb_done;
  logic                  wb_err;

  logic                  ram_req;
  logic [5:0]            ram_addr;
  logic [7:0]            ram_wen;
  logic [63:0]           ram_rdata;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_W-1:0]     aw_addr;
  logic [7:0]            aw_len;
  logic                  w_valid;
  logic                  w_ready;
  logic [63:0]           w_data;
  logic [7:0]            w_strb;
  logic                  w_last;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  modport master (
    input  wb_req_valid, wb_line_idx, wb_addr, ram_rdata,
    input  aw_ready, w_ready, b_valid, b_resp,
    output wb_req_ready, wb_done, wb_err, ram_req, ram_addr, ram_wen,
    output aw_valid, aw_addr, aw_len, w_valid, w_data, w_strb, w_last, b_ready
  );

  modport slave (
    output wb_req_valid, wb_line_idx, wb_addr, ram_rdata,
    output aw_ready, w_ready, b_valid, b_resp,
    input  wb_req_ready, wb_done, wb_err, ram_req, ram_addr, ram_wen,
    input  aw_valid, aw_addr, aw_len, w_valid, w_data, w_strb, w_last, b_ready
  );
endinterface

// File: rtl/d_cache_wb_fifo.sv
// Two-entry 64-bit FIFO between the RAM read pipeline and the W channel.
// Push and pop in the same cycle are accepted even when full.
module d_cache_wb_fifo
  import d_cache_wb_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic [63:0] head,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);
  logic [63:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= ZEROWORD;
      mem[1] <= ZEROWORD;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/d_cache_wb_unit.sv
// Dirty-line writeback engine: reads one line out of the 64x64 data RAM
// (1-cycle read latency) and sends it to memory as a single AW/W/B burst.
module d_cache_wb_unit
  import d_cache_wb_unit_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int LINE_IDX_W     = 6 - $clog2(WORDS_PER_LINE),
  parameter int ADDR_W         = 64
) (
  input  logic              clk,
  input  logic              rst,
  d_cache_wb_unit_if.master bus,
  output wb_state_e         dbg_state
);
  localparam int                WI         = $clog2(WORDS_PER_LINE);
  localparam int                CW         = WI + 1;
  localparam logic [CW-1:0]     N_WORDS    = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0]     LAST_IDX   = CW'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORDS_PER_LINE * 8 - 1);

  wb_state_e             state;
  wb_state_e             next_state;
  logic [LINE_IDX_W-1:0] line_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         wr_cnt;
  logic                  inflight;

  logic                  accept;
  logic                  rd_phase;
  logic                  issue;
  logic                  w_valid_int;
  logic                  w_last_int;
  logic                  pop;
  logic [63:0]           fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;

  assign accept   = (state == ST_IDLE) && bus.wb_req_valid;
  assign rd_phase = (state == ST_ADDR) || (state == ST_DATA);
  // Buffered plus in-flight words never exceed the two FIFO slots.
  assign issue    = rd_phase && (rd_cnt < N_WORDS) && !fifo_full &&
                    (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
  assign pop      = w_valid_int && bus.w_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.wb_req_valid)     next_state = ST_ADDR;
      ST_ADDR: if (bus.aw_ready)         next_state = ST_DATA;
      ST_DATA: if (pop && w_last_int)    next_state = ST_RESP;
      ST_RESP: if (bus.b_valid)          next_state = ST_IDLE;
      default:                           next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid_int      = (state == ST_DATA) && !fifo_empty;
    w_last_int       = w_valid_int && (wr_cnt == LAST_IDX);
    bus.wb_req_ready = (state == ST_IDLE);
    bus.aw_valid     = (state == ST_ADDR);
    bus.w_valid      = w_valid_int;
    bus.w_last       = w_last_int;
    bus.b_ready      = (state == ST_RESP);
    bus.wb_done      = (state == ST_RESP) && bus.b_valid;
    bus.wb_err       = bus.wb_done && (bus.b_resp != RESP_OKAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q   <= '0;
      addr_q   <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (accept) begin
        line_q <= bus.wb_line_idx;
        addr_q <= bus.wb_addr & ALIGN_MASK;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (issue) rd_cnt <= rd_cnt + CW'(1);
        if (pop)   wr_cnt <= wr_cnt + CW'(1);
      end
    end
  end

  d_cache_wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.ram_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The RAM port stays claimed until the last word's data has been captured.
  assign bus.ram_req  = rd_phase && ((rd_cnt != N_WORDS) || inflight);
  assign bus.ram_addr = {line_q, rd_cnt[WI-1:0]};
  assign bus.ram_wen  = 8'h00;
  assign bus.aw_addr  = addr_q;
  assign bus.aw_len   = 8'(WORDS_PER_LINE - 1);
  assign bus.w_data   = fifo_head;
  assign bus.w_strb   = 8'hFF;
  assign dbg_state    = state;

endmodule

// File: tb/tb_d_cache_wb_unit.sv
// Directed bench for d_cache_wb_unit: RAM model, AW/W/B responder driven from
// one initial block, and an expected-word queue checked on every W beat.
module tb_d_cache_wb_unit;
  import d_cache_wb_unit_pkg::*;

  localparam int N   = 4;
  localparam int WI  = $clog2(N);
  localparam int LIW = 6 - WI;
  localparam int AW  = 64;

  logic      clk = 1'b0;
  logic      rst;
  wb_state_e dbg_state;

  d_cache_wb_unit_if #(.LINE_IDX_W(LIW), .ADDR_W(AW)) bus ();

  d_cache_wb_unit #(.WORDS_PER_LINE(N), .LINE_IDX_W(LIW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [63:0] ram_mem [64];
  always_ff @(posedge clk) bus.ram_rdata <= ram_mem[bus.ram_addr];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  bit          wpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_burst(input int line, input logic [63:0] addr, input int aw_delay,
                          input int wmode, input int b_delay, input logic [1:0] resp,
                          input int abort_at, input bit hold_req,
                          input int next_line, input logic [63:0] next_addr);
    int          beats, issued, last_cyc;
    bit          aw_done, done, stalled;
    logic [63:0] prev_data, exp_aw, exp_w;
    logic        prev_last;
    logic [WI-1:0] prev_idx, cur_idx;
    exp_aw = addr & ~64'(N * 8 - 1);
    for (int i = 0; i < N; i++) exp_q.push_back(ram_mem[line * N + i]);
    bus.wb_req_valid = 1'b1;
    bus.wb_line_idx  = LIW'(line);
    bus.wb_addr      = addr;
    #1;
    check("req_ready_idle", bus.wb_req_ready, 1);
    check("done_idle", bus.wb_done, 0);
    @(negedge clk);
    if (hold_req) begin
      bus.wb_line_idx = LIW'(next_line);
      bus.wb_addr     = next_addr;
    end else begin
      bus.wb_req_valid = 1'b0;
    end
    beats = 0; issued = 0; last_cyc = 0; aw_done = 0; done = 0; stalled = 0;
    prev_idx = '0; prev_data = '0; prev_last = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (abort_at > 0 && beats == abort_at) break;
      bus.aw_ready = (cyc >= aw_delay);
      case (wmode)
        0:       bus.w_ready = 1'b1;
        1:       bus.w_ready = wpat[cyc % 6];
        default: bus.w_ready = 1'($urandom_range(0, 1));
      endcase
      bus.b_valid = (beats == N) && (cyc >= last_cyc + b_delay);
      bus.b_resp  = bus.b_valid ? resp : 2'b00;
      #1;
      // Each read issue advances the word index seen on ram_addr.
      cur_idx = bus.ram_addr[WI-1:0];
      if (cur_idx != prev_idx) issued++;
      prev_idx = cur_idx;
      check("outstanding_le2", (issued - beats) <= 2, 1);
      if (aw_delay >= 4 && cyc == aw_delay - 1) check("aw_stall_reads", issued, 2);
      check("req_ready_busy", bus.wb_req_ready, 0);
      check("ram_wen", bus.ram_wen, 0);
      check("aw_valid", bus.aw_valid, !aw_done);
      if (bus.aw_valid) begin
        check("aw_addr", bus.aw_addr, exp_aw);
        check("aw_len", bus.aw_len, N - 1);
      end
      if (!aw_done) check("w_before_aw", bus.w_valid, 0);
      if (stalled) begin
        check("w_hold_valid", bus.w_valid, 1);
        check("w_hold_data", bus.w_data, prev_data);
        check("w_hold_last", bus.w_last, prev_last);
      end
      check("b_ready", bus.b_ready, beats == N);
      check("wb_done", bus.wb_done, (beats == N) && bus.b_valid);
      if (beats == N && bus.b_valid) begin
        check("wb_err", bus.wb_err, resp != 2'b00);
        done = 1;
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("w_data", bus.w_data, exp_w);
        end
        check("w_strb", bus.w_strb, 8'hFF);
        check("w_last", bus.w_last, beats == N - 1);
        beats++;
        if (beats == N) last_cyc = cyc;
      end
      if (bus.aw_valid && bus.aw_ready) aw_done = 1;
      stalled   = bus.w_valid && !bus.w_ready;
      prev_data = bus.w_data;
      prev_last = bus.w_last;
      @(negedge clk);
    end
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    bus.b_resp   = 2'b00;
    if (abort_at == 0 && !done) check("burst_timeout", 0, 1);
    check("beat_count", beats, (abort_at > 0) ? abort_at : N);
  endtask

  initial begin
    rst = 1'b0;
    bus.wb_req_valid = 1'b0;
    bus.wb_line_idx  = '0;
    bus.wb_addr      = '0;
    bus.aw_ready     = 1'b0;
    bus.w_ready      = 1'b0;
    bus.b_valid      = 1'b0;
    bus.b_resp       = 2'b00;
    for (int i = 0; i < 64; i++) ram_mem[i] = {$urandom, $urandom};
    ram_mem[12] = 64'h11; ram_mem[13] = 64'h22; ram_mem[14] = 64'h33; ram_mem[15] = 64'h44;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", bus.wb_req_ready, 1);
    check("rst_wb_done", bus.wb_done, 0);
    check("rst_wb_err", bus.wb_err, 0);
    check("rst_ram_req", bus.ram_req, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_wen", bus.ram_wen, 0);
    check("rst_aw_valid", bus.aw_valid, 0);
    check("rst_aw_addr", bus.aw_addr, 0);
    check("rst_aw_len", bus.aw_len, N - 1);
    check("rst_w_valid", bus.w_valid, 0);
    check("rst_w_data", bus.w_data, 0);
    check("rst_w_strb", bus.w_strb, 8'hFF);
    check("rst_w_last", bus.w_last, 0);
    check("rst_b_ready", bus.b_ready, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_burst(3, 64'h8000_0047, 0, 0, 2, 2'b00, 0, 0, 0, 0);
    do_burst(5, 64'h8000_1158, 0, 1, 1, 2'b00, 0, 0, 0, 0);
    do_burst(7, 64'h1234_5678_9ABC_DEF7, 10, 0, 1, 2'b00, 0, 0, 0, 0);
    do_burst(2, 64'h0000_0000_0000_1FFF, 0, 0, 1, 2'b10, 0, 0, 0, 0);
    do_burst(9, 64'hFFFF_FFFF_FFFF_FFE5, 3, 2, 3, 2'b00, 0, 0, 0, 0);
    do_burst(0, 64'h4000_0000, 0, 0, 1, 2'b00, 0, 1, 1, 64'h4000_0020);
    do_burst(1, 64'h4000_0020, 0, 0, 1, 2'b00, 0, 0, 0, 0);

    do_burst(4, 64'h9000_0100, 0, 0, 1, 2'b00, 2, 0, 0, 0);
    rst = 1'b0;
    #1;
    check("midrst_w_valid", bus.w_valid, 0);
    check("midrst_aw_valid", bus.aw_valid, 0);
    check("midrst_ram_req", bus.ram_req, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", bus.wb_req_ready, 1);
    check("midrst_w_after", bus.w_valid, 0);
    @(negedge clk);
    do_burst(4, 64'h9000_0100, 0, 2, 1, 2'b00, 0, 0, 0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
